// File: rtl/adc_pkg.sv
// Shared definitions for the ADC burst sequencer: state encoding and default widths.
package adc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_TRIG   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FINISH = 3'd4
   } adc_state_t;

   localparam int ADC_DATA_W     = 12;
   localparam int ADC_TIMER_W    = 24;
   localparam int ADC_CNT_W      = 8;
   localparam int ADC_TMO_CYCLES = 65535;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter used for the pre-conversion settle delay.
// expired is high while the count is zero; the counter parks at zero.
module seq_timer
   import adc_pkg::*;
#(
   parameter int W = ADC_TIMER_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Load on request, otherwise count down towards zero and hold there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/adc_seq_ctrl.sv
// ADC burst sequencer: settle delay, convert pulse, capture, repeated
// n_samples times, then a done pulse.
// Optional build macro ADC_TIMEOUT_EN adds a conversion timeout in WAIT
// that pulses error and returns to IDLE after TMO_CYCLES clocks.
module adc_seq_ctrl
   import adc_pkg::*;
#(
   parameter int DATA_W     = ADC_DATA_W,
   parameter int TIMER_W    = ADC_TIMER_W,
   parameter int CNT_W      = ADC_CNT_W,
   parameter int TMO_CYCLES = ADC_TMO_CYCLES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [TIMER_W-1:0] settle_cycles,
   input  logic [CNT_W-1:0]   n_samples,
   output logic               adc_start,
   input  logic               adc_done,
   input  logic [DATA_W-1:0]  adc_data,
   output logic               sample_valid,
   output logic [DATA_W-1:0]  sample_data,
   output logic               busy,
   output logic               done,
   output logic               error
);

   adc_state_t         state, state_nxt;
   logic [TIMER_W-1:0] settle_lat;
   logic [CNT_W-1:0]   cnt_rem;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_load_val;
   logic               tmr_expired;
   logic               accept;
   logic               capture;

`ifdef ADC_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   logic        tmo_hit;
   logic        err_q;
`endif

   assign accept  = (state == ST_IDLE) && start && !abort;
   assign capture = (state == ST_WAIT) && adc_done && !abort;

   // Timer reloads on every entry into SETTLE; from IDLE the latch is being
   // written on the same edge, so take the live input there.
   assign tmr_load     = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);
   assign tmr_load_val = (state == ST_IDLE) ? settle_cycles : settle_lat;

   seq_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .expired  (tmr_expired)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; abort overrides every other condition
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:
               if (start)
                  state_nxt = (n_samples == '0) ? ST_FINISH : ST_SETTLE;
            ST_SETTLE:
               if (tmr_expired)
                  state_nxt = ST_TRIG;
            ST_TRIG:
               state_nxt = ST_WAIT;
            ST_WAIT: begin
               if (adc_done)
                  state_nxt = (cnt_rem == CNT_W'(1)) ? ST_FINISH : ST_SETTLE;
`ifdef ADC_TIMEOUT_EN
               else if (tmo_hit)
                  state_nxt = ST_IDLE;
`endif
            end
            ST_FINISH:
               state_nxt = ST_IDLE;
            default:
               state_nxt = ST_IDLE;
         endcase
      end
   end

   // Moore outputs decoded from state; done is suppressed by a same-cycle abort
   always_comb begin
      adc_start = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      if (state == ST_TRIG)
         adc_start = 1'b1;
      if (state != ST_IDLE)
         busy = 1'b1;
      if ((state == ST_FINISH) && !abort)
         done = 1'b1;
   end

   // Burst parameters, remaining count and sample capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_lat   <= '0;
         cnt_rem      <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (accept) begin
            settle_lat <= settle_cycles;
            cnt_rem    <= n_samples;
         end
         if (capture) begin
            sample_data  <= adc_data;
            sample_valid <= 1'b1;
            cnt_rem      <= cnt_rem - CNT_W'(1);
         end
      end
   end

`ifdef ADC_TIMEOUT_EN
   assign tmo_hit = (tmo_cnt == 32'(TMO_CYCLES - 1));

   // Conversion watchdog: counts cycles spent in WAIT, clears elsewhere
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= (state == ST_WAIT) && !adc_done && !abort && tmo_hit;
         if (state == ST_WAIT)
            tmo_cnt <= tmo_cnt + 32'd1;
         else
            tmo_cnt <= '0;
      end
   end

   assign error = err_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: doc/adc_seq_ctrl.md
ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 12, ADC sample width.
REQ-002 SHALL have parameter TIMER_W, default 24, settle-timer width.
REQ-003 SHALL have parameter CNT_W, default 8, sample-count width.
REQ-004 SHALL have parameter TMO_CYCLES, default 65535, conversion timeout in clk cycles (used only with ADC_TIMEOUT_EN).
REQ-005 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin burst; sampled only in IDLE.
- abort  in  1  cancel burst; return to IDLE.
- settle_cycles  in  TIMER_W  delay before each conversion; latched at start.
- n_samples  in  CNT_W  conversions per burst; latched at start.
- adc_start  out  1  one-cycle convert pulse to the ADC.
- adc_done  in  1  ADC conversion complete, with adc_data valid the same cycle.
- adc_data  in  DATA_W  conversion result.
- sample_valid  out  1  one-cycle strobe; sample_data valid.
- sample_data  out  DATA_W  captured result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal burst end.
- error  out  1  one-cycle pulse on timeout (tied 0 without ADC_TIMEOUT_EN).

Function
REQ-006 SHALL implement states IDLE, SETTLE, TRIG, WAIT, FINISH.
REQ-007 IDLE: start=1 and abort=0 SHALL latch settle_cycles and n_samples, then go to SETTLE; if latched n_samples=0, SHALL go to FINISH instead.
REQ-008 SETTLE SHALL load the timer with the latched settle value on entry and leave for TRIG on the cycle the timer expires; settle value 0 SHALL spend exactly one cycle in SETTLE.
REQ-009 TRIG SHALL assert adc_start for exactly one cycle, then go to WAIT.
REQ-010 WAIT: adc_done=1 SHALL register adc_data into sample_data, pulse sample_valid the next cycle, and decrement the remaining count.
REQ-011 After capture, remaining count non-zero SHALL go to SETTLE; remaining count zero SHALL go to FINISH.
REQ-012 FINISH SHALL pulse done for one cycle, then go to IDLE.
REQ-013 abort=1 in any state SHALL force IDLE on the next edge with no done pulse; abort SHALL win over start and adc_done in the same cycle.
REQ-014 start while busy=1 and adc_done outside WAIT SHALL be ignored.
REQ-015 Remaining count SHALL be CNT_W bits; n_samples=2^CNT_W-1 SHALL yield exactly that many conversions with no wrap.
REQ-016 sample_data SHALL hold its last value until the next capture.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE, timer and count to 0, and adc_start, sample_valid, sample_data, busy, done and error to 0.
REQ-018 Reset mid-burst SHALL discard the burst; the next burst SHALL require a new start.

Configuration
REQ-019 With ADC_TIMEOUT_EN defined, WAIT SHALL count cycles; reaching TMO_CYCLES without adc_done SHALL pulse error for one cycle and go to IDLE with no done pulse.
REQ-020 Without ADC_TIMEOUT_EN, WAIT SHALL wait indefinitely, and error SHALL be constant 0.

Structure
REQ-021 State encoding typedef and default widths SHALL live in shared package adc_pkg.
REQ-022 The settle timer SHALL be sub-module seq_timer, with ports:
- load, load value and expired.
- Behaviour: loadable down-counter that flags expiry at zero.

Verification
REQ-023 Basic burst:
- Stimulus: settle_cycles=3, n_samples=2, adc_done 2 cycles after each adc_start.
- Required: exactly 2 adc_start pulses, each 4 cycles after SETTLE entry; 2 sample_valid pulses with correct data; then done.
REQ-024 Zero settle, zero count:
- Stimulus: settle_cycles=0 with n_samples=1.
- Required: adc_start 2 cycles after start.
- Stimulus: n_samples=0.
- Required: done within 2 cycles and no adc_start.
REQ-025 Abort mid-burst:
- Stimulus: abort during WAIT of sample 1 of 4.
- Required: IDLE next cycle, busy=0, no done pulse; a late adc_done produces no sample_valid.
REQ-026 Start while busy:
- Stimulus: start pulses while busy.
- Required: ignored; burst count unchanged.
- Stimulus: start and abort together in IDLE.
- Required: stays IDLE.
REQ-027 Timeout (ADC_TIMEOUT_EN, TMO_CYCLES=10):
- Stimulus: adc_done never asserted.
- Required: error pulse 10 cycles after entering WAIT, then IDLE.
- Without the macro: remains in WAIT.
REQ-028 Async reset:
- Stimulus: rst_n pulsed low mid-SETTLE between clock edges.
- Required: outputs 0 immediately, IDLE after release.
